pwm_generator_multi: RTL

Parameterised N-channel ESC pulse generator; the next generation of the fixed 4-motor PWM stage that follows motor_mixer.
- Converts per-channel motor rates into standard servo/ESC pulses on a fixed frame.
- Adds features the 4-motor stage lacks: frame-synchronous double-buffered updates, pulse-width saturation, an arming sequence, and a stale-data failsafe.
- Sits between the motor mixer (or any rate source) and the motor output pins.

---
 rtl/pwm_generator_multi.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_generator_multi.sv
// pwm_generator_multi
//   N-channel ESC pulse generator on a fixed frame, clocked at 1 MHz so that
//   one clock equals one microsecond. Rates are double-buffered (shadow ->
//   active at the frame boundary), widths saturate at MAX_PULSE_US, and an
//   arming state machine with a stale-data failsafe gates the throttle.
//
// Ports
//   us_clk       in   1 MHz clock, the only clock
//   resetn       in   asynchronous active-low reset
//   rates_in     in   NUM_CH*RATE_WIDTH, channel k at [k*RATE_WIDTH +: RATE_WIDTH]
//   rates_valid  in   one-cycle strobe qualifying rates_in
//   arm_req      in   level, high requests arming
//   pwm_out      out  NUM_CH per-channel pulse outputs
//   armed        out  high while in ARMED
//   failsafe     out  high while in FAILSAFE
//   frame_start  out  one-cycle strobe during the frame_cnt==0 cycle
//
// Optional build macro
//   PWM_IDLE_LOW_EN  when defined, pwm_out stays low outside ARMED instead of
//                    emitting a MIN_PULSE_US idle pulse every frame.

module pwm_generator_multi #(
  parameter int NUM_CH       = 4,
  parameter int RATE_WIDTH   = 8,
  parameter int MIN_PULSE_US = 1000,
  parameter int MAX_PULSE_US = 2000,
  parameter int PULSE_SCALE  = 4,
  parameter int FRAME_US     = 2500,
  parameter int ARM_FRAMES   = 200,
  parameter int STALE_FRAMES = 50
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic [NUM_CH*RATE_WIDTH-1:0] rates_in,
  input  logic                         rates_valid,
  input  logic                         arm_req,
  output logic [NUM_CH-1:0]            pwm_out,
  output logic                         armed,
  output logic                         failsafe,
  output logic                         frame_start
);

  localparam int FW        = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam int AW        = $clog2(ARM_FRAMES + 1);
  localparam int SW        = $clog2(STALE_FRAMES + 1);
  localparam int RB        = NUM_CH * RATE_WIDTH;
  // Width register sized for the largest unsaturated width so that
  // MIN + rate*SCALE can never wrap before the saturation compare.
  localparam int W_RAW_MAX = MIN_PULSE_US + ((2 ** RATE_WIDTH) - 1) * PULSE_SCALE;
  localparam int W_TOP     = (W_RAW_MAX > MAX_PULSE_US) ? W_RAW_MAX : MAX_PULSE_US;
  localparam int WW        = $clog2(W_TOP + 1);
  localparam int CW        = (FW > WW) ? FW : WW;

`ifdef PWM_IDLE_LOW_EN
  localparam logic [WW-1:0] IDLE_W = '0;
`else
  localparam logic [WW-1:0] IDLE_W = WW'(MIN_PULSE_US);
`endif

  typedef enum logic [1:0] {DISARMED, ARMING, ARMED, FAILSAFE} state_t;

  state_t        state;
  logic [FW-1:0] frame_cnt;
  logic [AW-1:0] arm_cnt;
  logic [SW-1:0] stale_cnt;
  logic [RB-1:0] shadow;
  logic [RB-1:0] active;

  logic frame_zero;
  logic frame_last;
  logic arm_done;
  logic stale_trip;
  logic next_armed;
  logic [NUM_CH-1:0] pulse_next;

  function automatic logic [WW-1:0] sat_width(input logic [RATE_WIDTH-1:0] rate);
    logic [WW-1:0] raw;
    raw = WW'(MIN_PULSE_US) + WW'(rate) * WW'(PULSE_SCALE);
    return (raw > WW'(MAX_PULSE_US)) ? WW'(MAX_PULSE_US) : raw;
  endfunction

  assign frame_zero = (frame_cnt == '0);
  assign frame_last = (frame_cnt == FW'(FRAME_US - 1));
  assign arm_done   = (arm_cnt == AW'(ARM_FRAMES - 1));
  // A strobe on the boundary cycle clears the counter, so it cannot trip.
  assign stale_trip = !rates_valid && (stale_cnt == SW'(STALE_FRAMES - 1));
  // Whether the frame beginning at this boundary will be an ARMED frame.
  assign next_armed = arm_req && (((state == ARMING) && arm_done) ||
                                  ((state == ARMED) && !stale_trip));

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_last;
      frame_cnt   <= frame_last ? '0 : frame_cnt + FW'(1);
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (rates_valid) shadow <= rates_in;
      if (frame_zero)  active <= shadow;
    end
  end

  // Stale counting runs every cycle; the state case comes last so that
  // entering ARMED overrides it with a clean count.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= DISARMED;
      arm_cnt   <= '0;
      stale_cnt <= '0;
      armed     <= 1'b0;
      failsafe  <= 1'b0;
    end else begin
      armed    <= (state == ARMED);
      failsafe <= (state == FAILSAFE);
      if (rates_valid) begin
        stale_cnt <= '0;
      end else if (frame_zero && (state == ARMED)) begin
        stale_cnt <= stale_cnt + SW'(1);
      end
      if (frame_zero) begin
        case (state)
          DISARMED: begin
            if (arm_req) begin
              state   <= ARMING;
              arm_cnt <= '0;
            end
          end
          ARMING: begin
            if (!arm_req) begin
              state <= DISARMED;
            end else if (arm_done) begin
              state     <= ARMED;
              stale_cnt <= '0;
            end else begin
              arm_cnt <= arm_cnt + AW'(1);
            end
          end
          ARMED: begin
            if (!arm_req) begin
              state <= DISARMED;
            end else if (stale_trip) begin
              state <= FAILSAFE;
            end
          end
          FAILSAFE: begin
            if (!arm_req) state <= DISARMED;
          end
          default: state <= DISARMED;
        endcase
      end
    end
  end

  // On the boundary cycle the active rates and state are about to change, so
  // the first pulse sample of the new frame is taken from the values the frame
  // will actually use; otherwise an idle-low build would clip or glitch.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [WW-1:0] eff_w;
    logic [WW-1:0] head_w;
    assign eff_w  = (state == ARMED) ? sat_width(active[k*RATE_WIDTH +: RATE_WIDTH]) : IDLE_W;
    assign head_w = next_armed ? sat_width(shadow[k*RATE_WIDTH +: RATE_WIDTH]) : IDLE_W;
    assign pulse_next[k] = frame_zero ? (head_w != '0) : (CW'(frame_cnt) < CW'(eff_w));
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pulse_next;
    end
  end

endmodule
